// File: rtl/tlb_pkg.sv
// Shared widths and entry layout for the 16-entry paired-page JTLB.
// Imported by the storage top level and the lookup sub-module.
package tlb_pkg;

    localparam int TLBNUM = 16;
    localparam int IDXW   = $clog2(TLBNUM);
    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int PFN_W  = 20;
    localparam int C_W    = 3;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [C_W-1:0]   c;
        logic             d;
        logic             v;
    } tlb_page_t;

    // Field order is also the order of the r_* read-back bundle.
    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        tlb_page_t         p0;
        tlb_page_t         p1;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_lookup.sv
// One combinational search port: tag match over all entries, lowest index wins,
// then even/odd page select. All outputs are zero on a miss.
module tlb_lookup
    import tlb_pkg::*;
(
    input  logic [TLBNUM-1:0][VPN2_W-1:0] tag_vpn2,
    input  logic [TLBNUM-1:0][ASID_W-1:0] tag_asid,
    input  logic [TLBNUM-1:0]             tag_g,
    input  tlb_page_t [TLBNUM-1:0]        page0,
    input  tlb_page_t [TLBNUM-1:0]        page1,
    input  logic [VPN2_W-1:0]             vpn2,
    input  logic                          odd_page,
    input  logic [ASID_W-1:0]             asid,
    output logic                          found,
    output logic [IDXW-1:0]               index,
    output logic [PFN_W-1:0]              pfn,
    output logic [C_W-1:0]                c,
    output logic                          d,
    output logic                          v
);

    logic [TLBNUM-1:0] match;
    tlb_page_t         sel;

    // V does not take part in the match; an invalid page still hits.
    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            match[i] = (tag_vpn2[i] == vpn2) && (tag_g[i] || (tag_asid[i] == asid));
        end
    end

    // Scan from the top down so the lowest matching index is the last one kept.
    always_comb begin
        found = 1'b0;
        index = '0;
        sel   = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (match[i]) begin
                found = 1'b1;
                index = IDXW'(i);
                sel   = odd_page ? page1[i] : page0[i];
            end
        end
    end

    assign pfn = sel.pfn;
    assign c   = sel.c;
    assign d   = sel.d;
    assign v   = sel.v;

endmodule

// File: rtl/tlb.sv
// 16-entry fully associative MIPS32 JTLB: flop storage, TLBWI write port,
// TLBR read port and two independent combinational search ports.
module tlb
    import tlb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic [VPN2_W-1:0] s0_vpn2,
    input  logic              s0_odd_page,
    input  logic [ASID_W-1:0] s0_asid,
    output logic              s0_found,
    output logic [IDXW-1:0]   s0_index,
    output logic [PFN_W-1:0]  s0_pfn,
    output logic [C_W-1:0]    s0_c,
    output logic              s0_d,
    output logic              s0_v,

    input  logic [VPN2_W-1:0] s1_vpn2,
    input  logic              s1_odd_page,
    input  logic [ASID_W-1:0] s1_asid,
    output logic              s1_found,
    output logic [IDXW-1:0]   s1_index,
    output logic [PFN_W-1:0]  s1_pfn,
    output logic [C_W-1:0]    s1_c,
    output logic              s1_d,
    output logic              s1_v,

    input  logic              we,
    input  logic [IDXW-1:0]   w_index,
    input  logic [VPN2_W-1:0] w_vpn2,
    input  logic [ASID_W-1:0] w_asid,
    input  logic              w_g,
    input  logic [PFN_W-1:0]  w_pfn0,
    input  logic [C_W-1:0]    w_c0,
    input  logic              w_d0,
    input  logic              w_v0,
    input  logic [PFN_W-1:0]  w_pfn1,
    input  logic [C_W-1:0]    w_c1,
    input  logic              w_d1,
    input  logic              w_v1,

    input  logic [IDXW-1:0]   r_index,
    output logic [VPN2_W-1:0] r_vpn2,
    output logic [ASID_W-1:0] r_asid,
    output logic              r_g,
    output logic [PFN_W-1:0]  r_pfn0,
    output logic [C_W-1:0]    r_c0,
    output logic              r_d0,
    output logic              r_v0,
    output logic [PFN_W-1:0]  r_pfn1,
    output logic [C_W-1:0]    r_c1,
    output logic              r_d1,
    output logic              r_v1
);

    tlb_entry_t entries [TLBNUM];
    tlb_entry_t w_entry;
    tlb_entry_t r_entry;

    logic [TLBNUM-1:0][VPN2_W-1:0] tag_vpn2;
    logic [TLBNUM-1:0][ASID_W-1:0] tag_asid;
    logic [TLBNUM-1:0]             tag_g;
    tlb_page_t [TLBNUM-1:0]        page0;
    tlb_page_t [TLBNUM-1:0]        page1;

    assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                       p0: '{pfn: w_pfn0, c: w_c0, d: w_d0, v: w_v0},
                       p1: '{pfn: w_pfn1, c: w_c1, d: w_d1, v: w_v1}};

    // No bypass: a write lands at the edge and is seen only from the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                entries[i] <= '0;
            end
        end else if (we) begin
            entries[w_index] <= w_entry;
        end
    end

    always_comb begin
        for (int i = 0; i < TLBNUM; i++) begin
            tag_vpn2[i] = entries[i].vpn2;
            tag_asid[i] = entries[i].asid;
            tag_g[i]    = entries[i].g;
            page0[i]    = entries[i].p0;
            page1[i]    = entries[i].p1;
        end
    end

    tlb_lookup u_lookup_s0 (
        .tag_vpn2 (tag_vpn2),
        .tag_asid (tag_asid),
        .tag_g    (tag_g),
        .page0    (page0),
        .page1    (page1),
        .vpn2     (s0_vpn2),
        .odd_page (s0_odd_page),
        .asid     (s0_asid),
        .found    (s0_found),
        .index    (s0_index),
        .pfn      (s0_pfn),
        .c        (s0_c),
        .d        (s0_d),
        .v        (s0_v)
    );

    tlb_lookup u_lookup_s1 (
        .tag_vpn2 (tag_vpn2),
        .tag_asid (tag_asid),
        .tag_g    (tag_g),
        .page0    (page0),
        .page1    (page1),
        .vpn2     (s1_vpn2),
        .odd_page (s1_odd_page),
        .asid     (s1_asid),
        .found    (s1_found),
        .index    (s1_index),
        .pfn      (s1_pfn),
        .c        (s1_c),
        .d        (s1_d),
        .v        (s1_v)
    );

    assign r_entry = entries[r_index];
    assign r_vpn2  = r_entry.vpn2;
    assign r_asid  = r_entry.asid;
    assign r_g     = r_entry.g;
    assign r_pfn0  = r_entry.p0.pfn;
    assign r_c0    = r_entry.p0.c;
    assign r_d0    = r_entry.p0.d;
    assign r_v0    = r_entry.p0.v;
    assign r_pfn1  = r_entry.p1.pfn;
    assign r_c1    = r_entry.p1.c;
    assign r_d1    = r_entry.p1.d;
    assign r_v1    = r_entry.p1.v;

endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed scenarios followed by random write/search/read
// traffic scored against an array-based model of the TLB contents.
module tb_tlb;
    import tlb_pkg::*;

    logic              clk;
    logic              reset;
    logic [VPN2_W-1:0] s0_vpn2, s1_vpn2;
    logic              s0_odd_page, s1_odd_page;
    logic [ASID_W-1:0] s0_asid, s1_asid;
    logic              s0_found, s1_found;
    logic [IDXW-1:0]   s0_index, s1_index;
    logic [PFN_W-1:0]  s0_pfn, s1_pfn;
    logic [C_W-1:0]    s0_c, s1_c;
    logic              s0_d, s1_d, s0_v, s1_v;
    logic              we;
    logic [IDXW-1:0]   w_index;
    logic [VPN2_W-1:0] w_vpn2;
    logic [ASID_W-1:0] w_asid;
    logic              w_g;
    logic [PFN_W-1:0]  w_pfn0, w_pfn1;
    logic [C_W-1:0]    w_c0, w_c1;
    logic              w_d0, w_v0, w_d1, w_v1;
    logic [IDXW-1:0]   r_index;
    logic [VPN2_W-1:0] r_vpn2;
    logic [ASID_W-1:0] r_asid;
    logic              r_g;
    logic [PFN_W-1:0]  r_pfn0, r_pfn1;
    logic [C_W-1:0]    r_c0, r_c1;
    logic              r_d0, r_v0, r_d1, r_v1;

    tlb dut (
        .clk(clk), .reset(reset),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    tlb_entry_t    m_ent [16];
    logic [127:0]  exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] model_search(input logic [18:0] vpn2, input logic odd,
                                                 input logic [7:0] asid);
        for (int i = 0; i < 16; i++) begin
            if (m_ent[i].vpn2 == vpn2 && (m_ent[i].g || m_ent[i].asid == asid)) begin
                if (odd)
                    return {1'b1, 4'(i), m_ent[i].p1.pfn, m_ent[i].p1.c, m_ent[i].p1.d, m_ent[i].p1.v};
                else
                    return {1'b1, 4'(i), m_ent[i].p0.pfn, m_ent[i].p0.c, m_ent[i].p0.d, m_ent[i].p0.v};
            end
        end
        return '0;
    endfunction

    function automatic logic [29:0] obs_s0();
        return {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v};
    endfunction

    function automatic logic [29:0] obs_s1();
        return {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v};
    endfunction

    function automatic logic [77:0] obs_r();
        return {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_ent[i] = '0;
    endtask

    task automatic check_all(input string tag);
        exp_q.push_back(128'(model_search(s0_vpn2, s0_odd_page, s0_asid)));
        exp_q.push_back(128'(model_search(s1_vpn2, s1_odd_page, s1_asid)));
        exp_q.push_back(128'(m_ent[r_index]));
        check({tag, "_s0"}, 128'(obs_s0()), exp_q.pop_front());
        check({tag, "_s1"}, 128'(obs_s1()), exp_q.pop_front());
        check({tag, "_r"},  128'(obs_r()),  exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_s0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
    endtask

    task automatic set_s1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
    endtask

    task automatic drive_write(input logic [3:0] idx, input tlb_entry_t e);
        we = 1'b1; w_index = idx;
        w_vpn2 = e.vpn2; w_asid = e.asid; w_g = e.g;
        w_pfn0 = e.p0.pfn; w_c0 = e.p0.c; w_d0 = e.p0.d; w_v0 = e.p0.v;
        w_pfn1 = e.p1.pfn; w_c1 = e.p1.c; w_d1 = e.p1.d; w_v1 = e.p1.v;
    endtask

    task automatic do_write(input logic [3:0] idx, input tlb_entry_t e);
        @(negedge clk);
        drive_write(idx, e);
        @(posedge clk);
        if (!reset) m_ent[idx] = e;
        #1;
        we = 1'b0;
    endtask

    function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                      input logic [19:0] pfn0, input logic [2:0] c0, input logic d0,
                                      input logic v0, input logic [19:0] pfn1, input logic [2:0] c1,
                                      input logic d1, input logic v1);
        return '{vpn2: vpn2, asid: asid, g: g,
                 p0: '{pfn: pfn0, c: c0, d: d0, v: v0},
                 p1: '{pfn: pfn1, c: c1, d: d1, v: v1}};
    endfunction

    function automatic tlb_entry_t rand_entry();
        return mk(19'($urandom_range(0, 7)), 8'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    tlb_entry_t e;

    initial begin
        reset = 1'b1; we = 1'b0; w_index = '0;
        drive_write(4'd0, '0);
        we = 1'b0;
        set_s0('0, 1'b0, '0); set_s1('0, 1'b0, '0); r_index = '0;
        model_clear();

        // 1: outputs during reset
        #12;
        set_s0(19'h7FFFF, 1'b0, 8'h12);
        r_index = 4'd5;
        #1;
        check("t1_s0_miss", 128'(obs_s0()), 128'd0);
        check("t1_r5_zero", 128'(obs_r()), 128'd0);
        check_all("t1");
        @(negedge clk);
        reset = 1'b0;

        // 2: single entry, both pages
        e = mk(19'h00400, 8'h01, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b0);
        do_write(4'd3, e);
        set_s1(19'h00400, 1'b0, 8'h01);
        #1;
        check("t2_even", 128'(obs_s1()), 128'({1'b1, 4'd3, 20'h12345, 3'd3, 1'b1, 1'b1}));
        s1_odd_page = 1'b1;
        #1;
        check("t2_odd", 128'(obs_s1()), 128'({1'b1, 4'd3, 20'h54321, 3'd2, 1'b0, 1'b0}));

        // 3: ASID mismatch, then global
        set_s1(19'h00400, 1'b0, 8'h02);
        #1;
        check("t3_asid_miss", 128'(obs_s1()), 128'd0);
        e.g = 1'b1;
        do_write(4'd3, e);
        set_s1(19'h00400, 1'b0, 8'h02);
        r_index = 4'd3;
        #1;
        check("t3_g_hit02", 128'({s1_found, s1_index}), 128'({1'b1, 4'd3}));
        s1_asid = 8'hFF;
        #1;
        check("t3_g_hitff", 128'({s1_found, s1_index}), 128'({1'b1, 4'd3}));
        check("t3_r_g", 128'(r_g), 128'd1);
        check_all("t3");

        // 4: same-cycle write is not visible to search
        @(negedge clk);
        set_s0(19'h00001, 1'b0, 8'h00);
        e = mk(19'h00001, 8'h00, 1'b0, 20'hABCDE, 3'd1, 1'b0, 1'b1, 20'h0F0F0, 3'd5, 1'b1, 1'b1);
        drive_write(4'd7, e);
        #1;
        check("t4_same_cycle", 128'(s0_found), 128'd0);
        @(posedge clk);
        m_ent[7] = e;
        #1;
        we = 1'b0;
        check("t4_next_cycle", 128'({s0_found, s0_index}), 128'({1'b1, 4'd7}));

        // 5: duplicates resolve to the lowest index; independent ports
        do_write(4'd9, mk(19'h0002A, 8'h05, 1'b0, 20'h99999, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
        do_write(4'd2, mk(19'h0002A, 8'h05, 1'b0, 20'h22222, 3'd4, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
        set_s0(19'h0002A, 1'b0, 8'h05);
        set_s1(19'h0002A, 1'b0, 8'h05);
        #1;
        check("t5_dup_s0", 128'({s0_found, s0_index, s0_pfn}), 128'({1'b1, 4'd2, 20'h22222}));
        check("t5_dup_s1", 128'({s1_found, s1_index, s1_pfn}), 128'({1'b1, 4'd2, 20'h22222}));
        set_s0(19'h00400, 1'b0, 8'h01);
        set_s1(19'h00001, 1'b0, 8'h00);
        #1;
        check("t5_indep_s0", 128'({s0_found, s0_index}), 128'({1'b1, 4'd3}));
        check("t5_indep_s1", 128'({s1_found, s1_index}), 128'({1'b1, 4'd7}));
        check_all("t5");

        // 6: asynchronous reset after a fill, then a write coincident with reset
        for (int i = 0; i < 16; i++) begin
            e = rand_entry();
            e.vpn2 = 19'(i + 'h100);
            do_write(4'(i), e);
        end
        set_s0(19'h105, 1'b1, m_ent[5].asid);
        r_index = 4'd5;
        #1;
        check("t6_pre_hit", 128'({s0_found, s0_index}), 128'({1'b1, 4'd5}));
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        check("t6_async_s0", 128'(obs_s0()), 128'd0);
        check("t6_async_r", 128'(obs_r()), 128'd0);
        @(negedge clk);
        drive_write(4'd4, mk(19'h00077, 8'h3, 1'b1, 20'hFFFFF, 3'd7, 1'b1, 1'b1,
                             20'hFFFFF, 3'd7, 1'b1, 1'b1));
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        r_index = 4'd4;
        set_s0(19'h00077, 1'b0, 8'h3);
        #1;
        check("t6_we_in_reset_r", 128'(obs_r()), 128'd0);
        check("t6_we_in_reset_s", 128'(s0_found), 128'd0);

        // random traffic
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                do_write(4'($urandom_range(0, 15)), rand_entry());
            end
            @(negedge clk);
            set_s0(19'($urandom_range(0, 8)), 1'($urandom), 8'($urandom_range(0, 3)));
            set_s1(19'($urandom_range(0, 8)), 1'($urandom), 8'($urandom_range(0, 3)));
            r_index = 4'($urandom_range(0, 15));
            #1;
            check_all("rnd");
        end

        summary();
        $finish;
    end

endmodule
